// File: rtl/mem_ctrl.sv
// mem_ctrl: sequences fetch/load/store requests onto the ram block's
// address latch, write enable, section select and output enable, and
// returns one response per request. Re-accessing the address that ram
// already holds skips the address-latch cycle.
module mem_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_reqValid,
  output logic              o_reqReady,
  input  logic [1:0]        i_reqOp,
  input  logic [ADDR_W-1:0] i_reqAddr,
  input  logic [DATA_W-1:0] i_reqWData,
  output logic              o_respValid,
  input  logic              i_respReady,
  output logic [DATA_W-1:0] o_respData,
  output logic              o_respErr,
  output logic [ADDR_W-1:0] o_ramAddress,
  output logic              o_ramAddressEn,
  output logic [DATA_W-1:0] o_ramWriteData,
  output logic              o_ramWriteEn,
  output logic              o_ramReadDataSelect,
  output logic              o_ramOutEnable,
  input  logic [DATA_W-1:0] i_ramReadData,
  output logic [CNT_W-1:0]  o_accessCount
);

  typedef enum logic [1:0] {IDLE, ADDR, ACCESS, RESP} state_t;

  localparam logic [1:0] OP_FETCH = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_STORE = 2'b10;
  localparam logic [1:0] OP_RSVD  = 2'b11;

  state_t              state;
  state_t              state_next;
  logic [1:0]          req_op;
  logic [ADDR_W-1:0]   req_addr;
  logic [DATA_W-1:0]   req_wdata;
  logic [ADDR_W-1:0]   last_addr;
  logic                last_valid;
  logic [DATA_W-1:0]   resp_data;
  logic                resp_err;
  logic [CNT_W-1:0]    access_count;
  logic                accept;
  logic                reuse;

  assign o_reqReady    = (state == IDLE) && !i_reset;
  assign accept        = i_reqValid && o_reqReady;
  assign reuse         = last_valid && (i_reqAddr == last_addr);
  assign o_respValid   = (state == RESP);
  assign o_respData    = resp_data;
  assign o_respErr     = resp_err;
  assign o_accessCount = access_count;

  // State register; reset abandons any access in flight.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state <= IDLE;
    else         state <= state_next;
  end

  // Next-state logic: reserved ops answer at once, reused addresses skip ADDR.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (i_reqOp == OP_RSVD) state_next = RESP;
          else if (reuse)         state_next = ACCESS;
          else                    state_next = ADDR;
        end
      end
      ADDR:    state_next = ACCESS;
      ACCESS:  state_next = RESP;
      RESP:    if (i_respReady) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request capture on accept; these only matter once a request is in flight.
  always_ff @(posedge i_clk) begin
    if (accept) begin
      req_op    <= i_reqOp;
      req_addr  <= i_reqAddr;
      req_wdata <= i_reqWData;
    end
  end

  // Mirror of the address latched inside ram; invalidated by reset because ram clears its own latch.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      last_addr  <= '0;
      last_valid <= 1'b0;
    end else if (state == ADDR) begin
      last_addr  <= req_addr;
      last_valid <= 1'b1;
    end
  end

  // Response payload: set on accept for reserved ops, captured from the bus at the end of ACCESS.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      resp_data <= '0;
      resp_err  <= 1'b0;
    end else if (accept) begin
      resp_data <= '0;
      resp_err  <= (i_reqOp == OP_RSVD);
    end else if (state == ACCESS) begin
      resp_data <= (req_op == OP_STORE) ? '0 : i_ramReadData;
    end
  end

  // Completed-access counter, free-running wrap.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)              access_count <= '0;
    else if (state == ACCESS) access_count <= access_count + 1'b1;
  end

  // ram strobes decoded from the state; idle defaults keep the data section selected.
  always_comb begin
    o_ramAddress        = last_addr;
    o_ramAddressEn      = 1'b0;
    o_ramWriteData      = '0;
    o_ramWriteEn        = 1'b0;
    o_ramReadDataSelect = 1'b1;
    o_ramOutEnable      = 1'b0;
    case (state)
      ADDR: begin
        o_ramAddress   = req_addr;
        o_ramAddressEn = 1'b1;
      end
      ACCESS: begin
        case (req_op)
          OP_FETCH: begin
            o_ramReadDataSelect = 1'b0;
            o_ramOutEnable      = 1'b1;
          end
          OP_LOAD: begin
            o_ramOutEnable = 1'b1;
          end
          OP_STORE: begin
            o_ramWriteEn   = 1'b1;
            o_ramWriteData = req_wdata;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed stimulus with a response scoreboard, a behavioural
// ram model on the shared bus, and a monitor that checks every response.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = 2'b00;
  logic [7:0]  req_addr = 8'h00;
  logic [7:0]  req_wdata = 8'h00;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [7:0]  resp_data;
  logic        resp_err;
  logic [7:0]  ram_address;
  logic        ram_address_en;
  logic [7:0]  ram_write_data;
  logic        ram_write_en;
  logic        ram_sel;
  logic        ram_oe;
  logic [7:0]  ram_rdata;
  logic [15:0] access_count;

  mem_ctrl #(.ADDR_W(8), .DATA_W(8), .CNT_W(16)) dut (
    .i_clk(clk), .i_reset(rst),
    .i_reqValid(req_valid), .o_reqReady(req_ready), .i_reqOp(req_op),
    .i_reqAddr(req_addr), .i_reqWData(req_wdata),
    .o_respValid(resp_valid), .i_respReady(resp_ready),
    .o_respData(resp_data), .o_respErr(resp_err),
    .o_ramAddress(ram_address), .o_ramAddressEn(ram_address_en),
    .o_ramWriteData(ram_write_data), .o_ramWriteEn(ram_write_en),
    .o_ramReadDataSelect(ram_sel), .o_ramOutEnable(ram_oe),
    .i_ramReadData(ram_rdata), .o_accessCount(access_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       err;
    int         lat;
    int         acc;
  } item_t;

  item_t sb[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int ae_cnt = 0, we_cnt = 0, oe_cnt = 0;
  logic [7:0] ae_addr = 8'h00, we_data = 8'h00;
  logic       oe_sel = 1'b1;

  // ram model: program and data sections, synchronously reset address latch
  logic [7:0] pmem [256];
  logic [7:0] dmem [256];
  logic [7:0] ram_lat = 8'h00;
  assign ram_rdata = ram_oe ? (ram_sel ? dmem[ram_lat] : pmem[ram_lat]) : 8'h00;

  initial begin
    for (int i = 0; i < 256; i++) begin
      pmem[i] = 8'(i ^ 8'h99);
      dmem[i] = 8'h00;
    end
    pmem[8'h20] = 8'hC3;
    forever begin
      @(posedge clk);
      if (ram_write_en) dmem[ram_lat] = ram_write_data;
      if (rst)                 ram_lat = 8'h00;
      else if (ram_address_en) ram_lat = ram_address;
    end
  end

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: strobe bookkeeping, latency, stability under backpressure, scoreboard pops
  initial begin
    logic       prev_valid = 1'b0;
    logic       prev_taken = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic       prev_err = 1'b0;
    item_t      it;
    forever begin
      @(negedge clk);
      if (ram_address_en) begin ae_cnt++; ae_addr = ram_address; end
      if (ram_write_en)   begin we_cnt++; we_data = ram_write_data; end
      if (ram_oe)         begin oe_cnt++; oe_sel = ram_sel; end
      chk("oe_we_exclusive", {31'd0, ram_oe && ram_write_en}, 32'd0);
      if (resp_valid && !prev_valid) begin
        if (sb.size() == 0) chk("unexpected_resp", 32'd1, 32'd0);
        else chk("resp_latency", 32'(cyc - sb[0].acc), 32'(sb[0].lat));
      end
      if (resp_valid && prev_valid && !prev_taken) begin
        chk("hold_data", {24'd0, resp_data}, {24'd0, prev_data});
        chk("hold_err", {31'd0, resp_err}, {31'd0, prev_err});
      end
      if (resp_valid && resp_ready && sb.size() > 0) begin
        it = sb.pop_front();
        chk("resp_data", {24'd0, resp_data}, {24'd0, it.data});
        chk("resp_err", {31'd0, resp_err}, {31'd0, it.err});
      end
      prev_valid = resp_valid;
      prev_taken = resp_valid && resp_ready;
      prev_data  = resp_data;
      prev_err   = resp_err;
    end
  end

  task automatic issue(input logic [1:0] op, input logic [7:0] addr, input logic [7:0] wd,
                       input bit exp_resp, input logic [7:0] ed, input logic ee, input int el);
    item_t it;
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 100) begin @(negedge clk); n++; end
    if (!req_ready) chk("req_ready_timeout", 32'd0, 32'd1);
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_wdata = wd;
    if (exp_resp) begin
      it.data = ed; it.err = ee; it.lat = el; it.acc = cyc;
      sb.push_back(it);
    end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((sb.size() != 0 || resp_valid) && n < 100) begin @(negedge clk); n++; end
    chk("drain", {31'd0, (sb.size() != 0 || resp_valid)}, 32'd0);
  endtask

  int ae0, we0, oe0;

  initial begin
    // reset state
    repeat (2) @(negedge clk);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_count", {16'd0, access_count}, 32'd0);
    chk("rst_sel", {31'd0, ram_sel}, 32'd1);
    chk("rst_strobes", {29'd0, ram_address_en, ram_write_en, ram_oe}, 32'd0);
    rst = 1'b0;
    #1 chk("release_ready", {31'd0, req_ready}, 32'd1);

    // store 0x5A to 0x10
    ae0 = ae_cnt; we0 = we_cnt;
    issue(2'b10, 8'h10, 8'h5A, 1'b1, 8'h00, 1'b0, 3);
    wait_idle();
    chk("st_ae_pulses", 32'(ae_cnt - ae0), 32'd1);
    chk("st_ae_addr", {24'd0, ae_addr}, 32'h10);
    chk("st_we_pulses", 32'(we_cnt - we0), 32'd1);
    chk("st_we_data", {24'd0, we_data}, 32'h5A);

    // load 0x10 reuses the latched address
    ae0 = ae_cnt;
    issue(2'b01, 8'h10, 8'h00, 1'b1, 8'h5A, 1'b0, 2);
    wait_idle();
    chk("ld_ae_pulses", 32'(ae_cnt - ae0), 32'd0);
    chk("ld_count", {16'd0, access_count}, 32'd2);

    // fetch 0x20 from the program section
    ae0 = ae_cnt; oe0 = oe_cnt;
    issue(2'b00, 8'h20, 8'h00, 1'b1, 8'hC3, 1'b0, 3);
    wait_idle();
    chk("fe_ae_pulses", 32'(ae_cnt - ae0), 32'd1);
    chk("fe_ae_addr", {24'd0, ae_addr}, 32'h20);
    chk("fe_oe_pulses", 32'(oe_cnt - oe0), 32'd1);
    chk("fe_sel", {31'd0, oe_sel}, 32'd0);
    chk("fe_count", {16'd0, access_count}, 32'd3);

    // reserved op: error response, no ram activity
    ae0 = ae_cnt; we0 = we_cnt; oe0 = oe_cnt;
    issue(2'b11, 8'h33, 8'hFF, 1'b1, 8'h00, 1'b1, 1);
    wait_idle();
    chk("rs_strobes", 32'((ae_cnt - ae0) + (we_cnt - we0) + (oe_cnt - oe0)), 32'd0);
    chk("rs_count", {16'd0, access_count}, 32'd3);

    // backpressure on a load of 0xA5
    issue(2'b10, 8'h40, 8'hA5, 1'b1, 8'h00, 1'b0, 3);
    wait_idle();
    resp_ready = 1'b0;
    issue(2'b01, 8'h40, 8'h00, 1'b1, 8'hA5, 1'b0, 2);
    for (int n = 0; n < 20 && !resp_valid; n++) @(negedge clk);
    chk("bp_valid", {31'd0, resp_valid}, 32'd1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_req_ready", {31'd0, req_ready}, 32'd0);
      chk("bp_data", {24'd0, resp_data}, 32'hA5);
      chk("bp_count", {16'd0, access_count}, 32'd5);
    end
    @(posedge clk);
    #1 resp_ready = 1'b1;
    wait_idle();

    // reset during a store's ACCESS cycle
    issue(2'b10, 8'h10, 8'h77, 1'b0, 8'h00, 1'b0, 0);
    @(posedge clk);
    #2 chk("ac_we_before", {31'd0, ram_write_en}, 32'd1);
    rst = 1'b1;
    #1;
    chk("ar_we", {31'd0, ram_write_en}, 32'd0);
    chk("ar_oe_ae", {30'd0, ram_oe, ram_address_en}, 32'd0);
    chk("ar_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("ar_req_ready", {31'd0, req_ready}, 32'd0);
    chk("ar_resp", {23'd0, resp_err, resp_data}, 32'd0);
    chk("ar_count", {16'd0, access_count}, 32'd0);
    chk("ar_sel", {31'd0, ram_sel}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("ar_release_ready", {31'd0, req_ready}, 32'd1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("ar_no_resp", {31'd0, resp_valid}, 32'd0);
    end

    // load to the same address must relatch it
    ae0 = ae_cnt;
    issue(2'b01, 8'h10, 8'h00, 1'b1, 8'h5A, 1'b0, 3);
    wait_idle();
    chk("rl_ae_pulses", 32'(ae_cnt - ae0), 32'd1);
    chk("rl_ae_addr", {24'd0, ae_addr}, 32'h10);
    chk("rl_count", {16'd0, access_count}, 32'd1);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
